// File: rtl/sevenseg_axi_if.sv
// AXI4-Lite bus bundle for the 7-segment peripheral.
// The master modport drives requests and the slave modport answers them.
interface sevenseg_axi_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/sevenseg_axi_slave.sv
// AXI4-Lite slave for the 7-segment peripheral: four 32-bit RW registers
// (DIGITS, CTRL, SCAN_DIV, SCRATCH) plus a time-multiplexed digit scanner
// driving active-low anodes, segments and decimal point.
module sevenseg_axi_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter int          C_NUM_DIGITS       = 8,
    parameter logic [31:0] C_SCAN_DIV_RST     = 32'd49999
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    sevenseg_axi_if.slave           s00_axi,
    output logic [C_NUM_DIGITS-1:0] an,
    output logic [6:0]              seg,
    output logic                    dp
);
    localparam int NB    = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W = (C_NUM_DIGITS > 1) ? $clog2(C_NUM_DIGITS) : 1;
    localparam int AMSB  = C_S_AXI_ADDR_WIDTH - 1;

    // Active-low hex font, {g,f,e,d,c,b,a}
    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
    logic [31:0]                   digits;
    logic [31:0]                   ctrl;
    logic [31:0]                   scan_div;
    logic [7:0]                    dp_mask;
    logic [7:0]                    blank_mask;
    logic                          enable;

    logic [31:0]      cnt;
    logic [IDX_W-1:0] idx;

    logic       wr_fire;
    logic       rd_fire;
    logic [1:0] wr_sel;
    logic [1:0] rd_sel;
    logic       unused_bits;

    assign digits     = regs[0];
    assign ctrl       = regs[1];
    assign scan_div   = regs[2];
    assign enable     = ctrl[0];
    assign dp_mask    = ctrl[15:8];
    assign blank_mask = ctrl[23:16];

    assign wr_sel = s00_axi.awaddr[AMSB -: 2];
    assign rd_sel = s00_axi.araddr[AMSB -: 2];

    // Address and data are taken together in one cycle; ready is a
    // same-cycle acknowledgement so each handshake is exactly one edge.
    assign wr_fire = s00_axi_aresetn & s00_axi.awvalid & s00_axi.wvalid & ~s00_axi.bvalid;
    assign rd_fire = s00_axi_aresetn & s00_axi.arvalid & ~s00_axi.rvalid;

    assign s00_axi.awready = wr_fire;
    assign s00_axi.wready  = wr_fire;
    assign s00_axi.arready = rd_fire;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.rresp   = 2'b00;

    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                           s00_axi.awaddr[AMSB-2:0], s00_axi.araddr[AMSB-2:0]};

    // Register file byte-lane writes and write-response handshake
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            regs[0]        <= '0;
            regs[1]        <= '0;
            regs[2]        <= C_SCAN_DIV_RST;
            regs[3]        <= '0;
            s00_axi.bvalid <= 1'b0;
        end else begin
            if (wr_fire) begin
                for (int b = 0; b < NB; b++) begin
                    if (s00_axi.wstrb[b])
                        regs[wr_sel][8*b +: 8] <= s00_axi.wdata[8*b +: 8];
                end
                s00_axi.bvalid <= 1'b1;
            end else if (s00_axi.bvalid && s00_axi.bready) begin
                s00_axi.bvalid <= 1'b0;
            end
        end
    end

    // Read data capture (pre-write value on a same-edge write) and read handshake
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi.rdata  <= '0;
            s00_axi.rvalid <= 1'b0;
        end else begin
            if (rd_fire) begin
                s00_axi.rdata  <= regs[rd_sel];
                s00_axi.rvalid <= 1'b1;
            end else if (s00_axi.rvalid && s00_axi.rready) begin
                s00_axi.rvalid <= 1'b0;
            end
        end
    end

    // Scan timer: dwell SCAN_DIV+1 clocks per digit; >= makes a lowered divider wrap at once
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            if (cnt >= scan_div) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(C_NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

    // Registered display drive for the current digit slot
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an <= '1;
            if (enable && !blank_mask[idx])
                an[idx] <= 1'b0;
            seg <= font(digits[{idx, 2'b00} +: 4]);
            dp  <= ~dp_mask[idx];
        end
    end
endmodule
